operand_slice_register: RTL and testbench

Parametrised operand register for the multiplier datapath: captures a WIDTH-bit operand and holds it as NSLICE slices of SLICE bits each. The whole slice set is exposed in parallel for the array multiplier. The slices are also streamed one per cycle over a valid/ready handshake for the sequential (slice-serial) multiplier. Sits between operand input and the partial-product units; replaces the fixed 4-bit/two-slice register.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/slice_select.sv | 41 ++++
 rtl/operand_slice_register.sv | 103 ++++++++++
 tb/tb_operand_slice_register.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath: default operand geometry,
// slice-index width helper and the operand-streaming state encoding.
package mult_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SLICE = 2;

    // Index width never collapses to zero bits, even for a single slice.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/slice_select.sv
// Combinational slice picker: maps a stream step and order to a slice position
// and extracts that slice from the operand. Shared with the partial-product sequencer.
module slice_select
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE,
    localparam int NSLICE = WIDTH / SLICE,
    localparam int IDXW = idx_width(NSLICE)
) (
    input  logic [WIDTH-1:0] operand,
    input  logic [IDXW-1:0]  count,
    input  logic             msb_first,
    output logic [SLICE-1:0] slice_out,
    output logic [IDXW-1:0]  slice_idx
);

    logic [IDXW-1:0]  w_idx;
    logic [SLICE-1:0] w_slice;

    // Step-to-position mapping as an AND-OR mux over constant positions.
    always_comb begin
        w_idx = {IDXW{1'b0}};
        for (int i = 0; i < NSLICE; i++) begin
            w_idx = w_idx | ({IDXW{count == IDXW'(i)}} &
                             (msb_first ? IDXW'(NSLICE - 1 - i) : IDXW'(i)));
        end
    end

    // Slice extraction with constant-width part-selects only.
    always_comb begin
        w_slice = {SLICE{1'b0}};
        for (int i = 0; i < NSLICE; i++) begin
            w_slice = w_slice | ({SLICE{w_idx == IDXW'(i)}} & operand[i*SLICE +: SLICE]);
        end
    end

    assign slice_idx = w_idx;
    assign slice_out = w_slice;

endmodule

// File: rtl/operand_slice_register.sv
// Operand register for the multiplier: holds a WIDTH-bit operand as parallel slices
// and streams those slices one per cycle over a valid/ready handshake.
module operand_slice_register
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE,
    localparam int NSLICE = WIDTH / SLICE,
    localparam int IDXW = idx_width(NSLICE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             msb_first,
    input  logic [WIDTH-1:0] in,
    output logic             ld_ready,
    output logic [WIDTH-1:0] slices,
    output logic [SLICE-1:0] slice_out,
    output logic [IDXW-1:0]  slice_idx,
    output logic             slice_valid,
    input  logic             slice_ready,
    output logic             last
);

    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_geometry
        $error("operand_slice_register: WIDTH must be a positive multiple of SLICE");
    end

    localparam logic [IDXW-1:0] LAST_CNT = IDXW'(NSLICE - 1);

    state_t            r_state;
    logic [WIDTH-1:0]  r_slices;
    logic              r_order;
    logic [IDXW-1:0]   r_cnt;
    logic              r_valid;

    logic              w_last;
    logic              w_accept;

    assign w_last   = r_valid && (r_cnt == LAST_CNT);
    // Combinational from slice_ready so a new operand follows the last slice with no bubble.
    assign ld_ready = (r_state == IDLE) || (w_last && slice_ready);
    assign w_accept = ld && ld_ready;

    // Load/stream control: capture on accept, advance on each transfer, idle after the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_slices <= {WIDTH{1'b0}};
            r_order  <= 1'b0;
            r_cnt    <= {IDXW{1'b0}};
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= STREAM;
                        r_slices <= in;
                        r_order  <= msb_first;
                        r_cnt    <= {IDXW{1'b0}};
                        r_valid  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        r_state  <= STREAM;
                        r_slices <= in;
                        r_order  <= msb_first;
                        r_cnt    <= {IDXW{1'b0}};
                        r_valid  <= 1'b1;
                    end else if (r_valid && slice_ready) begin
                        if (w_last) begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + IDXW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    slice_select #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) u_slice_select (
        .operand   (r_slices),
        .count     (r_cnt),
        .msb_first (r_order),
        .slice_out (slice_out),
        .slice_idx (slice_idx)
    );

    assign slices      = r_slices;
    assign slice_valid = r_valid;
    assign last        = w_last;

endmodule

// File: tb/tb_operand_slice_register.sv
// Scoreboard bench for operand_slice_register: 8-bit/2-bit main instance with directed
// and random traffic, plus the legacy 4-bit/2-bit configuration.
module tb_operand_slice_register;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int NS  = 4;
    localparam int W4  = 4;
    localparam int NS4 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          ld = 1'b0, msb_first = 1'b0, slice_ready = 1'b0;
    logic [W-1:0]  in = '0;
    logic          ld_ready, slice_valid, last;
    logic [W-1:0]  slices;
    logic [S-1:0]  slice_out;
    logic [1:0]    slice_idx;

    logic          ld4 = 1'b0, msb4 = 1'b0, ready4 = 1'b0;
    logic [W4-1:0] in4 = '0;
    logic          ld_ready4, valid4, last4;
    logic [W4-1:0] slices4;
    logic [S-1:0]  slice_out4;
    logic [0:0]    idx4;

    operand_slice_register #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst(rst), .ld(ld), .msb_first(msb_first), .in(in),
        .ld_ready(ld_ready), .slices(slices), .slice_out(slice_out),
        .slice_idx(slice_idx), .slice_valid(slice_valid),
        .slice_ready(slice_ready), .last(last)
    );

    operand_slice_register #(.WIDTH(W4), .SLICE(S)) dut4 (
        .clk(clk), .rst(rst), .ld(ld4), .msb_first(msb4), .in(in4),
        .ld_ready(ld_ready4), .slices(slices4), .slice_out(slice_out4),
        .slice_idx(idx4), .slice_valid(valid4),
        .slice_ready(ready4), .last(last4)
    );

    typedef struct {
        int val;
        int idx;
        bit lst;
    } ent_t;

    ent_t sb_q[$];
    ent_t leg_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;
    int   leg_exp = 0;

    // Expected k-th transfer of operand v: position by order, value by shift-and-mask.
    function automatic ent_t mk(int v, int n, int sw, int k, bit msb);
        ent_t e;
        e.idx = msb ? (n - 1 - k) : k;
        e.val = (v >> (sw * e.idx)) & ((1 << sw) - 1);
        e.lst = (k == n - 1);
        return e;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks remaining transfers of the current operand and pushes
    // the expected transfer sequence whenever a load is accepted.
    int       m_rem = 0;
    bit [7:0] m_slices = 8'h00;
    always @(negedge clk) begin
        bit exp_ready;
        if (rst) begin
            chk("rst_valid", int'(slice_valid), 0);
            chk("rst_slices", int'(slices), 0);
            chk("rst_ld_ready", int'(ld_ready), 1);
            chk("rst_slice_out", int'(slice_out), 0);
            chk("rst_idx", int'(slice_idx), 0);
            chk("rst_last", int'(last), 0);
            m_rem    = 0;
            m_slices = 8'h00;
        end else begin
            exp_ready = (m_rem == 0) || (m_rem == 1 && slice_ready);
            chk("ld_ready", int'(ld_ready), int'(exp_ready));
            chk("slice_valid", int'(slice_valid), int'(m_rem != 0));
            chk("slices", int'(slices), int'(m_slices));
            if (m_rem == 0) chk("idle_last", int'(last), 0);
            if (m_rem != 0 && slice_ready) m_rem--;
            if (ld && exp_ready) begin
                m_rem    = NS;
                m_slices = in;
                for (int k = 0; k < NS; k++) sb_q.push_back(mk(int'(in), NS, S, k, msb_first));
            end
        end
    end

    // Monitor: whatever is presented must match the head of the scoreboard; pop on transfer.
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            sb_q.delete();
        end else if (slice_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_slice", 1, 0);
            end else begin
                e = sb_q[0];
                chk("slice_out", int'(slice_out), e.val);
                chk("slice_idx", int'(slice_idx), e.idx);
                chk("last", int'(last), int'(e.lst));
                if (slice_ready) void'(sb_q.pop_front());
            end
        end
    end

    // Legacy-configuration monitor plus end-of-run drain checks.
    bit final_done = 1'b0;
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            leg_q.delete();
        end else begin
            chk("leg_slices", int'(slices4), leg_exp);
            chk("leg_valid", int'(valid4), int'(leg_q.size() != 0));
            if (valid4 && leg_q.size() != 0) begin
                e = leg_q[0];
                chk("leg_slice_out", int'(slice_out4), e.val);
                chk("leg_idx", int'(idx4), e.idx);
                chk("leg_last", int'(last4), int'(e.lst));
                if (ready4) void'(leg_q.pop_front());
            end
        end
        if (done && !final_done) begin
            final_done = 1'b1;
            chk("sb_drained", sb_q.size(), 0);
            chk("leg_drained", leg_q.size(), 0);
        end
    end

    task automatic cyc(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(logic [7:0] v, logic msb);
        ld = 1'b1; in = v; msb_first = msb;
        cyc();
        ld = 1'b0;
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        slice_ready = 1'b1;
        cyc(1);

        load(8'hB4, 1'b0);
        cyc(5);
        load(8'hB4, 1'b1);
        cyc(5);

        // Backpressure with an ignored load during the stall.
        load(8'hB4, 1'b0);
        cyc(1);
        slice_ready = 1'b0;
        ld = 1'b1; in = 8'h55;
        cyc(3);
        ld = 1'b0;
        slice_ready = 1'b1;
        cyc(5);

        // Back-to-back: 8'h1E held on ld until the last slice of 8'hB4 transfers.
        load(8'hB4, 1'b0);
        ld = 1'b1; in = 8'h1E; msb_first = 1'b0;
        cyc(4);
        ld = 1'b0;
        cyc(6);

        // Reset mid-stream, then a fresh operand.
        load(8'hB4, 1'b0);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        load(8'hFF, 1'b0);
        cyc(6);

        for (int i = 0; i < 400; i++) begin
            ld          = ($urandom_range(0, 2) == 0);
            in          = 8'($urandom);
            msb_first   = 1'($urandom);
            slice_ready = ($urandom_range(0, 3) != 0);
            rst         = ($urandom_range(0, 99) == 0);
            cyc(1);
        end
        rst = 1'b0; ld = 1'b0; slice_ready = 1'b1;
        cyc(8);

        // Legacy 4-bit configuration.
        ready4 = 1'b1;
        ld4 = 1'b1; in4 = 4'b1010; msb4 = 1'b0;
        cyc(1);
        ld4 = 1'b0;
        for (int k = 0; k < NS4; k++) leg_q.push_back(mk(10, NS4, S, k, 1'b0));
        leg_exp = 10;
        cyc(4);
        ld4 = 1'b1; in4 = 4'b0110; msb4 = 1'b1;
        cyc(1);
        ld4 = 1'b0;
        for (int k = 0; k < NS4; k++) leg_q.push_back(mk(6, NS4, S, k, 1'b1));
        leg_exp = 6;
        cyc(4);

        done = 1'b1;
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
